tinyodin_obi_mem_bridge: RTL and testbench
==========================================

Name: tinyodin_obi_mem_bridge

Overview:
- OBI slave endpoint that sits directly downstream of the tinyODIN OBI address demux.
- One instance per tinyODIN memory: spike, neuron or synapse.
- Converts an OBI request into single-port SRAM accesses; SRAM has word writes only, no byte enables.
- Partial byte-enable writes are done as read-modify-write. The SRAM port is shared with the tinyODIN core, which always has priority.

Parameters:
- ADDR_W, 8, SRAM word-address width (256 words for neuron memory).
- DATA_W, 32, SRAM and OBI data width; must be 32.
- RD_LAT, 1, SRAM read latency in cycles; legal range 1..2.
- req_t, logic, OBI request struct type (req, we, be, addr, wdata).
- rsp_t, logic, OBI response struct type (gnt, rvalid, rdata).

Ports:
- clk_i  input  1  single clock.
- rst_ni  input  1  synchronous, active-low reset.
- obi_req_i  input  req_t  request from the demux; addr is already a word address.
- obi_resp_o  output  rsp_t  gnt, rvalid, rdata back to the demux.
- core_busy_i  input  1  tinyODIN core owns the SRAM port this cycle.
- mem_cs_o  output  1  SRAM chip select.
- mem_we_o  output  1  SRAM write enable.
- mem_addr_o  output  ADDR_W  SRAM word address, taken from obi addr[ADDR_W-1:0]; upper bits are ignored.
- mem_wdata_o  output  DATA_W  SRAM write data.
- mem_rdata_i  input  DATA_W  SRAM read data, valid RD_LAT cycles after a read cs.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; latency counter 0.
- Synchronous reset asserted mid-operation: return to IDLE, drop any pending response (no rvalid), drive no SRAM access.
- At most one outstanding transaction. gnt=1 only in IDLE, and only when req=1 and core_busy_i=0. gnt is combinational.
- mem_cs_o is never asserted while core_busy_i=1.
- States: IDLE, RD_WAIT, RMW_WAIT, RMW_WR, WR_RESP.
- IDLE, read granted in cycle T: cs=1, we=0 at T. Go to RD_WAIT; counter counts RD_LAT.
  - rvalid=1 in cycle T+RD_LAT with rdata=mem_rdata_i; return to IDLE in that same cycle.
- IDLE, write with be=4'hF granted at T: cs=1, we=1, wdata=obi wdata at T. WR_RESP gives rvalid=1, rdata=0 at T+1.
- IDLE, write with be=0: no SRAM access; rvalid at T+1.
- IDLE, partial write (be not 0 and not F) granted at T: cs=1, we=0 at T. Latch addr, be and wdata; go to RMW_WAIT.
  - At T+RD_LAT, merge per byte: be[i] ? wdata byte : mem_rdata byte.
  - If core_busy_i=0 in that cycle: write the merged word (cs=1, we=1), go to WR_RESP.
  - Else hold the merged word in RMW_WR and write in the first cycle with core_busy_i=0.
  - rvalid comes the cycle after the write.
- rvalid is a one-cycle pulse; rdata=0 whenever rvalid=0.
- Back-to-back: a new gnt may coincide with the rvalid cycle of the previous read (FSM is in IDLE then). Requests arriving in WR_RESP are granted the next cycle.
- The SRAM is pipelined: core accesses in RD_WAIT or RMW_WAIT do not corrupt the bridge's pending read data.
- core_busy_i high in IDLE with req pending: gnt=0, request held by master; no timeout.

Decomposition:
- Shared package tinyodin_mem_pkg holds:
  - the state enum;
  - constant FULL_BE=4'hF;
  - function be_merge(old, new, be).
- No sub-module; the FSM plus counter fits one module.

Test Plan:
- RD_LAT=1, SRAM[0x10]=0xDEADBEEF, read addr 0x10 -> gnt at T, rvalid at T+1 with rdata 0xDEADBEEF.
- Full write 0x12345678 to 0x20, then read 0x20 -> write cs/we at grant cycle, rvalid T+1 with rdata 0; read returns 0x12345678.
- SRAM[0x30]=0xAABBCCDD, write wdata 0x11223344 be=4'b0101 -> one read then one write of 0xAA22CC44; rvalid the cycle after the write.
- core_busy_i held high 3 cycles while req=1 -> gnt=0 and mem_cs_o=0 for 3 cycles, gnt in the 4th. Repeat with busy during RMW_WR -> write is delayed, merged value unchanged.
- RD_LAT=2, back-to-back reads to 0x01 and 0x02 -> rvalid at T+2 and T+4; the second gnt coincides with the first rvalid.
- rst_ni low for one cycle during RMW_WAIT -> no rvalid, no SRAM write; SRAM contents unchanged; next request serviced normally.

Source files
------------

// File: rtl/tinyodin_obi_mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module : tinyodin_mem_pkg
// Brief  : Shared types, constants and the byte-merge helper used by the
//          tinyODIN OBI-to-SRAM bridge.
//          Contents:
//            bridge_state_e - bridge FSM state encoding
//            FULL_BE        - byte-enable value of a whole-word write
//            obi_req_t      - default OBI request struct (req, we, be, addr, wdata)
//            obi_rsp_t      - default OBI response struct (gnt, rvalid, rdata)
//            be_merge()     - per-byte merge of new data over an old word
// Rev    : 1.0 - initial release
// ============================================================================
package tinyodin_mem_pkg;

   localparam logic [3:0] FULL_BE = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_WAIT  = 3'd1,
      ST_RMW_WAIT = 3'd2,
      ST_RMW_WR   = 3'd3,
      ST_WR_RESP  = 3'd4
   } bridge_state_e;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_rsp_t;

   // Bytes whose enable is set come from new_w, the rest keep old_w.
   function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  be);
      logic [31:0] merged;
      merged = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = new_w[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tinyodin_obi_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module : tinyodin_obi_mem_bridge
// Brief  : OBI slave endpoint for one tinyODIN memory (spike, neuron or
//          synapse). Turns OBI requests into single-port SRAM accesses; byte
//          enabled partial writes become read-modify-write. The tinyODIN core
//          shares the SRAM port and always wins it.
// Ports  :
//   clk_i        in   clock
//   rst_ni       in   synchronous active-low reset
//   obi_req_i    in   OBI request (req, we, be, word addr, wdata)
//   obi_resp_o   out  OBI response (gnt, rvalid, rdata)
//   core_busy_i  in   core owns the SRAM port this cycle
//   mem_cs_o     out  SRAM chip select
//   mem_we_o     out  SRAM write enable
//   mem_addr_o   out  SRAM word address
//   mem_wdata_o  out  SRAM write data
//   mem_rdata_i  in   SRAM read data, RD_LAT cycles after a read select
// Rev    : 1.0 - initial release
// ============================================================================
module tinyodin_obi_mem_bridge
   import tinyodin_mem_pkg::*;
#(
   parameter int  ADDR_W = 8,
   parameter int  DATA_W = 32,
   parameter int  RD_LAT = 1,
   parameter type req_t  = obi_req_t,
   parameter type rsp_t  = obi_rsp_t
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  req_t              obi_req_i,
   output rsp_t              obi_resp_o,
   input  logic              core_busy_i,
   output logic              mem_cs_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam logic [1:0] c_RD_LAT = 2'(RD_LAT);

   bridge_state_e     state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   // Holds the write data of a partial write, later the merged word.
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic              w_rd_done;
   logic              w_can_accept;
   logic [DATA_W-1:0] w_merged;
   // Upper address bits are intentionally ignored.
   logic              w_unused_req;

   assign w_unused_req = ^obi_req_i;

   // The last read-wait cycle already behaves as IDLE so a new request can be
   // granted in the same cycle as the previous read's rvalid.
   assign w_rd_done    = (state_q == ST_RD_WAIT) && (cnt_q == c_RD_LAT);
   assign w_can_accept = (state_q == ST_IDLE) || w_rd_done;
   assign w_merged     = be_merge(mem_rdata_i, wdata_q, be_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      obi_resp_o  = '0;
      mem_cs_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;

      if (!rst_ni) begin
         // Reset cycle: no response, no SRAM access, whatever was pending.
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_RD_WAIT: begin
               if (cnt_q == c_RD_LAT) begin
                  obi_resp_o.rvalid = 1'b1;
                  obi_resp_o.rdata  = mem_rdata_i;
                  state_d           = ST_IDLE;
                  cnt_d             = '0;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
            ST_RMW_WAIT: begin
               if (cnt_q == c_RD_LAT) begin
                  cnt_d = '0;
                  if (!core_busy_i) begin
                     mem_cs_o    = 1'b1;
                     mem_we_o    = 1'b1;
                     mem_addr_o  = addr_q;
                     mem_wdata_o = w_merged;
                     state_d     = ST_WR_RESP;
                  end else begin
                     // Read data is only valid this cycle; keep the merge.
                     wdata_d = w_merged;
                     state_d = ST_RMW_WR;
                  end
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
            ST_RMW_WR: begin
               if (!core_busy_i) begin
                  mem_cs_o    = 1'b1;
                  mem_we_o    = 1'b1;
                  mem_addr_o  = addr_q;
                  mem_wdata_o = wdata_q;
                  state_d     = ST_WR_RESP;
               end
            end
            ST_WR_RESP: begin
               obi_resp_o.rvalid = 1'b1;
               state_d           = ST_IDLE;
            end
            default: begin
            end
         endcase

         if (w_can_accept && obi_req_i.req && !core_busy_i) begin
            obi_resp_o.gnt = 1'b1;
            addr_d         = obi_req_i.addr[ADDR_W-1:0];
            if (!obi_req_i.we) begin
               mem_cs_o   = 1'b1;
               mem_addr_o = obi_req_i.addr[ADDR_W-1:0];
               state_d    = ST_RD_WAIT;
               cnt_d      = 2'd1;
            end else if (obi_req_i.be == FULL_BE) begin
               mem_cs_o    = 1'b1;
               mem_we_o    = 1'b1;
               mem_addr_o  = obi_req_i.addr[ADDR_W-1:0];
               mem_wdata_o = obi_req_i.wdata;
               state_d     = ST_WR_RESP;
            end else if (obi_req_i.be == 4'h0) begin
               // Nothing to write; just acknowledge.
               state_d = ST_WR_RESP;
            end else begin
               mem_cs_o   = 1'b1;
               mem_addr_o = obi_req_i.addr[ADDR_W-1:0];
               be_d       = obi_req_i.be;
               wdata_d    = obi_req_i.wdata;
               state_d    = ST_RMW_WAIT;
               cnt_d      = 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tinyodin_obi_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module : tb_tinyodin_obi_mem_bridge
// Brief  : Self-checking bench for tinyodin_obi_mem_bridge. Two bridges
//          (RD_LAT=1 and RD_LAT=2), each with a pipelined SRAM model whose
//          port is shared with a reading core. A word-array reference memory
//          predicts read data, merged write values and response timing.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_tinyodin_obi_mem_bridge;
   import tinyodin_mem_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   obi_req_t    req_s  [2];
   obi_rsp_t    rsp_s  [2];
   logic        busy_s [2];
   logic        cs_s   [2];
   logic        we_s   [2];
   logic [7:0]  addr_s [2];
   logic [31:0] wd_s   [2];
   logic        load_en;
   logic [7:0]  load_a;
   logic [31:0] load_d [2];
   logic [31:0] ref_mem [2][256];
   int          n_cmp = 0;
   int          n_err = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = g + 1;
      logic [31:0] mem [256];
      logic [31:0] p0_d, p1_d, junk, rd;
      logic        p0_v, p1_v;
      logic [7:0]  core_a;

      tinyodin_obi_mem_bridge #(
         .ADDR_W (8),
         .DATA_W (32),
         .RD_LAT (LAT)
      ) u_dut (
         .clk_i       (clk),
         .rst_ni      (rst_n),
         .obi_req_i   (req_s[g]),
         .obi_resp_o  (rsp_s[g]),
         .core_busy_i (busy_s[g]),
         .mem_cs_o    (cs_s[g]),
         .mem_we_o    (we_s[g]),
         .mem_addr_o  (addr_s[g]),
         .mem_wdata_o (wd_s[g]),
         .mem_rdata_i (rd)
      );

      // Pipelined SRAM; the core issues reads whenever it owns the port.
      always @(posedge clk) begin
         junk   <= $urandom;
         core_a <= 8'($urandom);
         if (load_en) mem[load_a] <= load_d[g];
         if (cs_s[g] && we_s[g]) mem[addr_s[g]] <= wd_s[g];
         if (cs_s[g] && !we_s[g]) begin
            p0_v <= 1'b1;
            p0_d <= mem[addr_s[g]];
         end else if (busy_s[g]) begin
            p0_v <= 1'b1;
            p0_d <= mem[core_a];
         end else begin
            p0_v <= 1'b0;
         end
         p1_v <= p0_v;
         p1_d <= p0_d;
      end
      assign rd = (LAT == 1) ? (p0_v ? p0_d : junk) : (p1_v ? p1_d : junk);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_inv(input int d);
      chk($sformatf("cs_while_busy[%0d]", d), 32'(cs_s[d] && busy_s[d]), 32'd0);
      if (!rsp_s[d].rvalid) chk($sformatf("rdata_no_rvalid[%0d]", d), rsp_s[d].rdata, 32'd0);
   endtask

   task automatic drop_req(input int d);
      req_s[d]       = '0;
      req_s[d].we    = 1'($urandom);
      req_s[d].be    = 4'($urandom);
      req_s[d].addr  = $urandom;
      req_s[d].wdata = $urandom;
   endtask

   task automatic idle_cycles(input int d, input int n);
      for (int i = 0; i < n; i++) begin
         drop_req(d);
         busy_s[d] = 1'($urandom);
         @(negedge clk);
         chk($sformatf("idle_gnt[%0d]", d), 32'(rsp_s[d].gnt), 32'd0);
         chk($sformatf("idle_rvalid[%0d]", d), 32'(rsp_s[d].rvalid), 32'd0);
         chk($sformatf("idle_cs[%0d]", d), 32'(cs_s[d]), 32'd0);
         @(posedge clk); #1;
      end
      busy_s[d] = 1'b0;
   endtask

   // One complete OBI transaction. Called with the bridge idle at posedge+1.
   task automatic txn(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                      input logic [3:0] be_in, input int pre_busy, input int mid_busy);
      int          lat, exp_j, wr_j;
      bit          full, zero, partial;
      logic [31:0] exp_rd, merged;
      lat     = d + 1;
      full    = wr && (be_in == 4'hF);
      zero    = wr && (be_in == 4'h0);
      partial = wr && !full && !zero;
      exp_rd  = wr ? 32'd0 : ref_mem[d][a];
      merged  = ref_mem[d][a];
      for (int i = 0; i < 4; i++) if (be_in[i]) merged[8*i +: 8] = wd[8*i +: 8];
      wr_j    = lat + mid_busy;
      exp_j   = !wr ? lat : (partial ? wr_j + 1 : 1);

      req_s[d].req   = 1'b1;
      req_s[d].we    = wr;
      req_s[d].be    = be_in;
      req_s[d].addr  = {24'($urandom), a};
      req_s[d].wdata = wd;
      for (int k = 0; k <= pre_busy; k++) begin
         busy_s[d] = (k < pre_busy);
         @(negedge clk);
         chk($sformatf("gnt[%0d] k=%0d", d, k), 32'(rsp_s[d].gnt), 32'(k == pre_busy));
         chk($sformatf("grant_cs[%0d] k=%0d", d, k), 32'(cs_s[d]), 32'(k == pre_busy && !zero));
         chk_inv(d);
         if (k == pre_busy) begin
            chk($sformatf("grant_we[%0d]", d), 32'(we_s[d]), 32'(full));
            if (!zero) chk($sformatf("grant_addr[%0d]", d), 32'(addr_s[d]), 32'(a));
            if (full)  chk($sformatf("grant_wdata[%0d]", d), wd_s[d], wd);
         end
         @(posedge clk); #1;
      end

      drop_req(d);
      for (int j = 1; j <= exp_j; j++) begin
         if (partial && j >= lat && j < wr_j) busy_s[d] = 1'b1;
         else if (partial && j == wr_j)       busy_s[d] = 1'b0;
         else                                 busy_s[d] = 1'($urandom);
         @(negedge clk);
         chk($sformatf("rvalid[%0d] j=%0d", d, j), 32'(rsp_s[d].rvalid), 32'(j == exp_j));
         if (j == exp_j) chk($sformatf("rdata[%0d] a=%h", d, a), rsp_s[d].rdata, exp_rd);
         chk($sformatf("resp_cs[%0d] j=%0d", d, j), 32'(cs_s[d]), 32'(partial && j == wr_j));
         if (partial && j == wr_j) begin
            chk($sformatf("rmw_we[%0d]", d), 32'(we_s[d]), 32'd1);
            chk($sformatf("rmw_addr[%0d]", d), 32'(addr_s[d]), 32'(a));
            chk($sformatf("rmw_wdata[%0d]", d), wd_s[d], merged);
         end
         chk_inv(d);
         @(posedge clk); #1;
      end
      busy_s[d] = 1'b0;
      if (wr) ref_mem[d][a] = merged;
   endtask

   initial begin
      int          bad;
      logic [31:0] v;
      rst_n   = 1'b0;
      load_en = 1'b1;
      for (int d = 0; d < 2; d++) begin
         req_s[d]       = '0;
         req_s[d].req   = 1'b1;
         req_s[d].we    = 1'b1;
         req_s[d].be    = 4'hF;
         req_s[d].wdata = 32'hFFFF_FFFF;
         busy_s[d]      = 1'b0;
      end

      // Preload both SRAMs (and the reference) while the bridges sit in reset.
      for (int i = 0; i < 256; i++) begin
         load_a = 8'(i);
         for (int d = 0; d < 2; d++) begin
            v = $urandom;
            if (i == 'h10) v = 32'hDEAD_BEEF;
            if (i == 'h30) v = 32'hAABB_CCDD;
            load_d[d]     = v;
            ref_mem[d][i] = v;
         end
         @(posedge clk); #1;
      end
      load_en = 1'b0;

      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_gnt[%0d]", d), 32'(rsp_s[d].gnt), 32'd0);
         chk($sformatf("rst_rvalid[%0d]", d), 32'(rsp_s[d].rvalid), 32'd0);
         chk($sformatf("rst_rdata[%0d]", d), rsp_s[d].rdata, 32'd0);
         chk($sformatf("rst_cs[%0d]", d), 32'(cs_s[d]), 32'd0);
         chk($sformatf("rst_we[%0d]", d), 32'(we_s[d]), 32'd0);
         chk($sformatf("rst_addr[%0d]", d), 32'(addr_s[d]), 32'd0);
         chk($sformatf("rst_wdata[%0d]", d), wd_s[d], 32'd0);
      end
      @(posedge clk); #1;
      drop_req(0);
      drop_req(1);
      rst_n = 1'b1;
      idle_cycles(0, 1);

      // Directed cases on the RD_LAT=1 bridge.
      txn(0, 1'b0, 8'h10, 32'h0, 4'h0, 0, 0);
      txn(0, 1'b1, 8'h20, 32'h1234_5678, 4'hF, 0, 0);
      txn(0, 1'b0, 8'h20, 32'h0, 4'h0, 0, 0);
      txn(0, 1'b1, 8'h30, 32'h1122_3344, 4'b0101, 0, 0);
      txn(0, 1'b0, 8'h30, 32'h0, 4'h0, 0, 0);
      txn(0, 1'b0, 8'h10, 32'h0, 4'h0, 3, 0);
      txn(0, 1'b1, 8'h31, 32'h5566_7788, 4'b1010, 0, 3);
      txn(0, 1'b0, 8'h31, 32'h0, 4'h0, 0, 0);
      txn(0, 1'b1, 8'h32, 32'hCAFE_F00D, 4'h0, 1, 0);

      // RD_LAT=2 back-to-back reads: second grant lands on the first rvalid.
      req_s[1].req  = 1'b1;
      req_s[1].we   = 1'b0;
      req_s[1].addr = 32'h0000_0001;
      @(negedge clk);
      chk("b2b_gnt1", 32'(rsp_s[1].gnt), 32'd1);
      chk("b2b_cs1", 32'(cs_s[1]), 32'd1);
      @(posedge clk); #1;
      drop_req(1);
      @(negedge clk);
      chk("b2b_rvalid_t1", 32'(rsp_s[1].rvalid), 32'd0);
      @(posedge clk); #1;
      req_s[1].req  = 1'b1;
      req_s[1].we   = 1'b0;
      req_s[1].addr = 32'h0000_0002;
      @(negedge clk);
      chk("b2b_rvalid_t2", 32'(rsp_s[1].rvalid), 32'd1);
      chk("b2b_rdata_t2", rsp_s[1].rdata, ref_mem[1][1]);
      chk("b2b_gnt2", 32'(rsp_s[1].gnt), 32'd1);
      chk("b2b_cs2", 32'(cs_s[1]), 32'd1);
      chk("b2b_addr2", 32'(addr_s[1]), 32'h2);
      @(posedge clk); #1;
      drop_req(1);
      @(negedge clk);
      chk("b2b_rvalid_t3", 32'(rsp_s[1].rvalid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("b2b_rvalid_t4", 32'(rsp_s[1].rvalid), 32'd1);
      chk("b2b_rdata_t4", rsp_s[1].rdata, ref_mem[1][2]);
      @(posedge clk); #1;

      // Reset pulse while a partial write waits for its read data.
      req_s[1].req   = 1'b1;
      req_s[1].we    = 1'b1;
      req_s[1].be    = 4'b0011;
      req_s[1].addr  = 32'h0000_0040;
      req_s[1].wdata = 32'h0BAD_0BAD;
      @(negedge clk);
      chk("rstmid_gnt", 32'(rsp_s[1].gnt), 32'd1);
      @(posedge clk); #1;
      drop_req(1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rstmid_rvalid_in_rst", 32'(rsp_s[1].rvalid), 32'd0);
      chk("rstmid_cs_in_rst", 32'(cs_s[1]), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle_cycles(1, 3);
      txn(1, 1'b0, 8'h40, 32'h0, 4'h0, 0, 0);
      txn(1, 1'b1, 8'h41, 32'h99AA_BBCC, 4'b0110, 2, 2);
      txn(1, 1'b0, 8'h41, 32'h0, 4'h0, 0, 0);

      // Randomized traffic on both bridges.
      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 60; n++) begin
            logic [3:0] be_r;
            case ($urandom % 4)
               0:       be_r = 4'h0;
               1:       be_r = 4'hF;
               default: be_r = 4'($urandom);
            endcase
            txn(d, 1'($urandom), 8'($urandom), $urandom, be_r,
                int'($urandom % 3), int'($urandom % 3));
            idle_cycles(d, int'($urandom % 2));
         end
      end

      bad = 0;
      for (int i = 0; i < 256; i++) if (g_dut[0].mem[i] !== ref_mem[0][i]) bad++;
      chk("sram0_contents", 32'(bad), 32'd0);
      bad = 0;
      for (int i = 0; i < 256; i++) if (g_dut[1].mem[i] !== ref_mem[1][i]) bad++;
      chk("sram1_contents", 32'(bad), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
